// File: rtl/operand_stream_loader.sv
// Host-side front end of the Montgomery multiplier core: loads p'_0, p, a, b
// into the bridge BRAM, kicks the core, then streams the result words back out.
module operand_stream_loader #(
  parameter int unsigned s        = 8,
  localparam int unsigned AW      = $clog2(4 * s),
  parameter int unsigned P_PRIME_0_ADDR = 0,
  parameter int unsigned P_BASE   = 1,
  parameter int unsigned A_BASE   = s + 1,
  parameter int unsigned B_BASE   = 2 * s + 1,
  parameter int unsigned RES_BASE = s + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic [16:0]   s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [16:0]   m_data_o,
  output logic          m_valid_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic [AW-1:0] bram_addr_o,
  output logic [16:0]   bram_din_o,
  output logic          bram_we_o,
  output logic          bram_en_o,
  input  logic [16:0]   bram_dout_i,
  output logic          core_start_o,
  input  logic          core_done_i,
  output logic          busy_o
);

  localparam int unsigned DW = 17;
  localparam int unsigned CW = $clog2(3 * s + 1);
  localparam int unsigned RW = (s > 1) ? $clog2(s) : 1;

  typedef enum logic [2:0] {
    LOAD, START, WAIT_DONE, RD_REQ, RD_WAIT, OUT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [RW-1:0] res_cnt_q, res_cnt_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          core_start_q;
  logic [AW-1:0] load_addr;
  logic          res_last;

  // Map the incoming word index onto the p'_0 / p / a / b regions.
  always_comb begin
    load_addr = AW'(P_PRIME_0_ADDR);
    if (word_cnt_q == '0) begin
      load_addr = AW'(P_PRIME_0_ADDR);
    end else if (word_cnt_q <= CW'(s)) begin
      load_addr = AW'(P_BASE) + AW'(word_cnt_q) - AW'(1);
    end else if (word_cnt_q <= CW'(2 * s)) begin
      load_addr = AW'(A_BASE) + AW'(word_cnt_q) - AW'(s + 1);
    end else begin
      load_addr = AW'(B_BASE) + AW'(word_cnt_q) - AW'(2 * s + 1);
    end
  end

  assign res_last = (res_cnt_q == RW'(s - 1));

  // Next-state, counter and BRAM/stream handshake decode.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    res_cnt_d   = res_cnt_q;
    m_data_d    = m_data_q;
    s_ready_o   = 1'b0;
    bram_en_o   = 1'b0;
    bram_we_o   = 1'b0;
    bram_addr_o = '0;
    bram_din_o  = '0;
    m_valid_o   = 1'b0;
    m_last_o    = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          bram_en_o   = 1'b1;
          bram_we_o   = 1'b1;
          bram_din_o  = s_data_i;
          bram_addr_o = load_addr;
          if (word_cnt_q == CW'(3 * s)) begin
            state_d = START;
          end else begin
            word_cnt_d = word_cnt_q + CW'(1);
          end
        end
      end
      START: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (core_done_i) begin
          state_d   = RD_REQ;
          res_cnt_d = '0;
        end
      end
      RD_REQ: begin
        bram_en_o   = 1'b1;
        bram_addr_o = AW'(RES_BASE) + AW'(res_cnt_q);
        state_d     = RD_WAIT;
      end
      RD_WAIT: begin
        m_data_d = bram_dout_i;
        state_d  = OUT;
      end
      OUT: begin
        m_valid_o = 1'b1;
        m_last_o  = res_last;
        if (m_ready_i) begin
          if (!res_last) begin
            res_cnt_d = res_cnt_q + RW'(1);
            state_d   = RD_REQ;
          end else begin
            res_cnt_d  = '0;
            word_cnt_d = '0;
            state_d    = LOAD;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, counters, result word and the start pulse register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= LOAD;
      word_cnt_q   <= '0;
      res_cnt_q    <= '0;
      m_data_q     <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      res_cnt_q    <= res_cnt_d;
      m_data_q     <= m_data_d;
      core_start_q <= (state_q == START);
    end
  end

  assign m_data_o     = m_data_q;
  assign core_start_o = core_start_q;
  assign busy_o       = !((state_q == LOAD) && (word_cnt_q == '0));

endmodule

// File: doc/operand_stream_loader.md
Name: operand_stream_loader

Overview:
- Host-side front end of the Montgomery multiplier core. Talks to the core through the bridge BRAM and the core's start/done pins.
- Accepts an operand stream of 17-bit words (valid/ready) and writes p'_0, p, a and b into the bridge BRAM through the second BRAM port.
- Then pulses the core start, waits for core done, and streams the s result words back out (valid/ready, with last).

Parameters:
- s, 8, number of 17-bit sections per operand; must equal the core's s.
- AW, $clog2(4*s), bridge BRAM address width (derived; not to be overridden).
- P_PRIME_0_ADDR, 0, BRAM word address of p'_0.
- P_BASE, 1, BRAM address of p section 0; p occupies s words.
- A_BASE, s+1, BRAM address of a section 0; a occupies s words.
- B_BASE, 2*s+1, BRAM address of b section 0; b occupies s words.
- RES_BASE, s+1, BRAM address of result section 0. The core overwrites the a region with the result.

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- s_data_i  in  17  operand word.
- s_valid_i  in  1  operand word valid.
- s_ready_o  out  1  operand word accepted when s_valid_i && s_ready_o.
- m_data_o  out  17  result word.
- m_valid_o  out  1  result word valid.
- m_last_o  out  1  marks result section s-1.
- m_ready_i  in  1  downstream accepts the result word.
- bram_addr_o  out  AW  bridge BRAM address (this block's port).
- bram_din_o  out  17  BRAM write data.
- bram_we_o  out  1  BRAM write enable.
- bram_en_o  out  1  BRAM enable.
- bram_dout_i  in  17  BRAM read data, valid 1 cycle after a read with en=1, we=0.
- core_start_o  out  1  one-cycle start pulse to the multiplier top.
- core_done_i  in  1  multiplier top done (pulse; sampled high).
- busy_o  out  1  high in every state except LOAD with word count 0.

Behaviour:
- FSM states: LOAD (reset state), START, WAIT_DONE, RD_REQ, RD_WAIT, OUT.
- Reset (any state, any cycle) forces:
  - state to LOAD; word counter and result counter to 0;
  - s_ready_o=1, all other outputs 0, bram_addr_o=0, m_data_o=0.
  - An in-flight operation is abandoned with no start pulse and no output.
- LOAD:
  - s_ready_o=1.
  - Stream order is 3s+1 words: p'_0, p[0..s-1], a[0..s-1], b[0..s-1], least-significant section first.
  - Each handshake drives, combinationally in the same cycle: bram_en_o=1, bram_we_o=1, bram_din_o=s_data_i, bram_addr_o = the mapped address of word counter k:
    - k=0 maps to P_PRIME_0_ADDR;
    - k in 1..s maps to P_BASE+k-1;
    - k in s+1..2s maps to A_BASE+k-s-1;
    - k in 2s+1..3s maps to B_BASE+k-2s-1.
  - The counter increments on each handshake. s_valid_i low holds the counter (gaps allowed).
  - The handshake with k=3s moves to START.
- START:
  - core_start_o=1 for exactly one cycle; s_ready_o=0.
  - Next state is WAIT_DONE.
- WAIT_DONE:
  - Stay until core_done_i=1, then go to RD_REQ with the result counter at 0.
  - core_done_i seen in any other state is ignored.
- RD_REQ:
  - bram_en_o=1, bram_we_o=0, bram_addr_o=RES_BASE+result counter.
  - Next state is RD_WAIT.
- RD_WAIT: capture bram_dout_i into the output register, then go to OUT.
- OUT:
  - m_valid_o=1; m_data_o is held stable until the handshake; m_last_o=1 when result counter = s-1.
  - On m_ready_i: if counter < s-1, increment it and go to RD_REQ; else go to LOAD with the word counter cleared.
- Throughput: 3 cycles per result word with m_ready_i held high; 1 word/cycle on input.
- Address arithmetic: done in AW bits with no wrap. Default layout ends at address 3s, which is <= 2^AW - 1.
- s_valid_i outside LOAD: ignored and not consumed (s_ready_o=0).
- m_ready_i outside OUT: ignored.
- bram_en_o/bram_we_o are 0 in every cycle not listed above.

Test Plan:
1. s=8, reset, stream 25 words 0x00001..0x00019 with valid held high → 25 BRAM writes on consecutive cycles at addresses 0,1..8,9..16,17..24 carrying the matching data; core_start_o single pulse exactly 2 cycles after the last handshake (START entered the cycle after it); s_ready_o low from START on.
2. Hold core_done_i low for 100 cycles → no BRAM activity, busy_o=1. Pulse core_done_i with BRAM model addresses 9..16 preloaded 0x10..0x17 → m_data_o emits 0x10..0x17 in order, m_last_o only on 0x17; then back in LOAD with s_ready_o=1.
3. Randomly deassert s_valid_i and m_ready_i (~50%) → same BRAM write sequence and output sequence as scenarios 1/2; m_data_o stable while m_valid_o && !m_ready_i.
4. Assert reset_i after 12 input words, then send a full new 25-word stream → first write after reset goes to address 0; no core_start_o pulse before the 25th word.
5. Assert reset_i during OUT on result word 3 → m_valid_o=0 the next cycle. Pulse core_done_i while in LOAD → ignored, no reads issued.
6. Two back-to-back complete transactions → the second core_start_o occurs only after the first transaction's m_last_o handshake; results of both are correct.
